// File: rtl/eseram_bank_mapper.sv
// -----------------------------------------------------------------------------
// eseram_bank_mapper
//   Cartridge-slot memory mapper with four 8 KB bank registers (ASCII8 /
//   ESE-RAM style) covering 0x4000-0xBFFF. CPU cycles are translated into
//   single-outstanding, handshaked requests to an SDRAM arbiter port.
//   eseram_memory_id selects the 1 MB SDRAM window.
//
// Ports
//   clk21m, reset         : clock, asynchronous active-high reset
//   req/ack/wrt/adr/dbo/dbi: CPU side (req level held until ack, ack one pulse)
//   eseram_memory_id      : SDRAM window select, captured at request launch
//   mem_req/mem_ack       : SDRAM handshake (level request, pulse completion)
//   mem_wrt/mem_adr/mem_dbo/mem_dbi : SDRAM command and data
// -----------------------------------------------------------------------------
module eseram_bank_mapper #(
   parameter int BANK_BITS = 7,
   parameter int TIMEOUT   = 255
) (
   input  logic        clk21m,
   input  logic        reset,
   input  logic        req,
   output logic        ack,
   input  logic        wrt,
   input  logic [15:0] adr,
   input  logic [7:0]  dbo,
   output logic [7:0]  dbi,
   input  logic [4:0]  eseram_memory_id,
   output logic        mem_req,
   input  logic        mem_ack,
   output logic        mem_wrt,
   output logic [24:0] mem_adr,
   output logic [7:0]  mem_dbo,
   input  logic [7:0]  mem_dbi
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, MEM, DONE, RELEASE} state_t;

   state_t           r_state, w_state_nx;
   logic             r_ack, w_ack_nx;
   logic [7:0]       r_dbi, w_dbi_nx;
   logic             r_mem_req, w_mem_req_nx;
   logic             r_mem_wrt, w_mem_wrt_nx;
   logic [24:0]      r_mem_adr, w_mem_adr_nx;
   logic [7:0]       r_mem_dbo, w_mem_dbo_nx;
   logic [7:0]       r_bank [0:3];
   logic [7:0]       w_bank_nx [0:3];
   logic [CNT_W-1:0] r_cnt, w_cnt_nx;

   logic             w_in_range;
   logic [1:0]       w_page;
   logic             w_regwin_wr;
   logic [7:0]       w_bank;
   logic             w_wr_blocked;

   // Pages 0x4000/0x6000/0x8000/0xA000 have adr[15:13] = 010/011/100/101,
   // so adr[15:13]-2 reduces to {adr[15], adr[13]} inside the valid range.
   assign w_in_range   = (adr[15:14] == 2'b01) || (adr[15:14] == 2'b10);
   assign w_page       = {adr[15], adr[13]};
   assign w_regwin_wr  = wrt && (adr[15:13] == 3'b011);
   assign w_bank       = r_bank[w_page];
   assign w_wr_blocked = wrt && !w_bank[7];

   always_comb begin
      w_state_nx   = r_state;
      w_ack_nx     = 1'b0;
      w_dbi_nx     = r_dbi;
      w_mem_req_nx = r_mem_req;
      w_mem_wrt_nx = r_mem_wrt;
      w_mem_adr_nx = r_mem_adr;
      w_mem_dbo_nx = r_mem_dbo;
      w_cnt_nx     = r_cnt;
      for (int i = 0; i < 4; i++) w_bank_nx[i] = r_bank[i];

      case (r_state)
         IDLE: begin
            if (req) begin
               if (w_regwin_wr) begin
                  // Register window swallows the write; SDRAM never sees it.
                  w_bank_nx[adr[12:11]] = dbo;
                  w_state_nx            = DONE;
               end else if (!w_in_range || w_wr_blocked) begin
                  if (!wrt) w_dbi_nx = 8'hFF;
                  w_state_nx = DONE;
               end else begin
                  w_mem_req_nx = 1'b1;
                  w_mem_wrt_nx = wrt;
                  w_mem_adr_nx = 25'({eseram_memory_id, w_bank[BANK_BITS-1:0], adr[12:0]});
                  w_mem_dbo_nx = dbo;
                  w_cnt_nx     = '0;
                  w_state_nx   = MEM;
               end
            end
         end
         MEM: begin
            if (mem_ack) begin
               w_mem_req_nx = 1'b0;
               if (!r_mem_wrt) w_dbi_nx = mem_dbi;
               w_state_nx = DONE;
            end else if (r_cnt == CNT_W'(TIMEOUT)) begin
               // Arbiter never answered: release the bus and return open-bus data.
               w_mem_req_nx = 1'b0;
               w_dbi_nx     = 8'hFF;
               w_state_nx   = DONE;
            end else begin
               w_cnt_nx = r_cnt + 1'b1;
            end
         end
         DONE: begin
            w_ack_nx   = 1'b1;
            w_state_nx = RELEASE;
         end
         RELEASE: begin
            // Wait for the CPU to drop req so a held request is not replayed.
            if (!req) w_state_nx = IDLE;
         end
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk21m or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_ack     <= 1'b0;
         r_dbi     <= 8'hFF;
         r_mem_req <= 1'b0;
         r_mem_wrt <= 1'b0;
         r_mem_adr <= '0;
         r_mem_dbo <= '0;
         r_cnt     <= '0;
         r_bank[0] <= 8'h00;
         r_bank[1] <= 8'h01;
         r_bank[2] <= 8'h02;
         r_bank[3] <= 8'h03;
      end else begin
         r_state   <= w_state_nx;
         r_ack     <= w_ack_nx;
         r_dbi     <= w_dbi_nx;
         r_mem_req <= w_mem_req_nx;
         r_mem_wrt <= w_mem_wrt_nx;
         r_mem_adr <= w_mem_adr_nx;
         r_mem_dbo <= w_mem_dbo_nx;
         r_cnt     <= w_cnt_nx;
         for (int i = 0; i < 4; i++) r_bank[i] <= w_bank_nx[i];
      end
   end

   assign ack     = r_ack;
   assign dbi     = r_dbi;
   assign mem_req = r_mem_req;
   assign mem_wrt = r_mem_wrt;
   assign mem_adr = r_mem_adr;
   assign mem_dbo = r_mem_dbo;

endmodule

// File: tb/tb_eseram_bank_mapper.sv
module tb_eseram_bank_mapper;

   localparam int TIMEOUT = 255;

   logic        clk21m = 1'b0;
   logic        reset  = 1'b1;
   logic        req    = 1'b0;
   logic        ack;
   logic        wrt    = 1'b0;
   logic [15:0] adr    = '0;
   logic [7:0]  dbo    = '0;
   logic [7:0]  dbi;
   logic [4:0]  eseram_memory_id = '0;
   logic        mem_req;
   logic        mem_ack = 1'b0;
   logic        mem_wrt;
   logic [24:0] mem_adr;
   logic [7:0]  mem_dbo;
   logic [7:0]  mem_dbi = '0;

   int n_checks = 0;
   int n_pass   = 0;

   eseram_bank_mapper #(.BANK_BITS(7), .TIMEOUT(TIMEOUT)) dut (
      .clk21m(clk21m), .reset(reset), .req(req), .ack(ack), .wrt(wrt),
      .adr(adr), .dbo(dbo), .dbi(dbi), .eseram_memory_id(eseram_memory_id),
      .mem_req(mem_req), .mem_ack(mem_ack), .mem_wrt(mem_wrt),
      .mem_adr(mem_adr), .mem_dbo(mem_dbo), .mem_dbi(mem_dbi)
   );

   always #5 clk21m = ~clk21m;

   // Drives one CPU cycle and plays the SDRAM side. Cycle numbers count
   // negedges after req is raised; outputs are sampled on the negedge.
   task automatic do_access(input logic w, input logic [15:0] a, input logic [7:0] d,
                            input bit respond, input logic [7:0] rd, input int hold,
                            output bit saw_mreq, output logic [24:0] madr,
                            output logic mwrt, output logic [7:0] mdbo,
                            output int ack_cyc, output int ack_count,
                            output logic [7:0] dbi_at_ack, output int mreq_last);
      bit responded = 0;
      saw_mreq = 0; madr = '0; mwrt = 1'b0; mdbo = '0;
      ack_cyc = -1; ack_count = 0; dbi_at_ack = 8'h00; mreq_last = -1;
      @(negedge clk21m);
      req = 1'b1; wrt = w; adr = a; dbo = d;
      for (int n = 1; n <= 400; n++) begin
         @(negedge clk21m);
         mem_ack = 1'b0;
         if (mem_req) begin
            mreq_last = n;
            if (!saw_mreq) begin
               saw_mreq = 1; madr = mem_adr; mwrt = mem_wrt; mdbo = mem_dbo;
            end
            if (respond && !responded) begin
               mem_ack = 1'b1; mem_dbi = rd; responded = 1;
            end
         end
         if (ack) begin
            ack_count++;
            if (ack_cyc < 0) begin
               ack_cyc = n; dbi_at_ack = dbi;
            end
         end
         if (ack_cyc > 0 && n >= ack_cyc + hold) req = 1'b0;
         if (ack_cyc > 0 && n >= ack_cyc + hold + 3) break;
      end
      mem_ack = 1'b0;
      req = 1'b0;
   endtask

   bit          s_saw;
   logic [24:0] s_madr;
   logic        s_mwrt;
   logic [7:0]  s_mdbo;
   int          s_ack_cyc, s_ack_cnt, s_mreq_last;
   logic [7:0]  s_dbi;

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk21m);
      n_checks++;
      if (ack !== 1'b0 || mem_req !== 1'b0 || dbi !== 8'hFF || mem_adr !== 25'd0)
         $display("FAIL reset_in: ack=%b mem_req=%b dbi=%h mem_adr=%h want 0 0 ff 0", ack, mem_req, dbi, mem_adr);
      else n_pass++;
      reset = 1'b0;
      repeat (3) @(negedge clk21m);
      n_checks++;
      if (ack !== 1'b0 || mem_req !== 1'b0 || dbi !== 8'hFF)
         $display("FAIL reset_idle: ack=%b mem_req=%b dbi=%h want 0 0 ff", ack, mem_req, dbi);
      else n_pass++;
   endtask

   task automatic test_bank_defaults();
      logic [15:0] addrs [4] = '{16'h4000, 16'h6000, 16'h8000, 16'hA000};
      eseram_memory_id = 5'd0;
      for (int i = 0; i < 4; i++) begin
         do_access(1'b0, addrs[i], 8'h00, 1, 8'h11, 0, s_saw, s_madr, s_mwrt, s_mdbo,
                   s_ack_cyc, s_ack_cnt, s_dbi, s_mreq_last);
         n_checks++;
         if (!s_saw || s_madr[19:13] !== 7'(i) || s_madr[12:0] !== 13'd0)
            $display("FAIL default_bank%0d: saw=%0d bank=%h want %h", i, s_saw, s_madr[19:13], i);
         else n_pass++;
      end
   endtask

   task automatic test_bank_write_read();
      eseram_memory_id = 5'd21;
      do_access(1'b1, 16'h6800, 8'h85, 1, 8'h00, 0, s_saw, s_madr, s_mwrt, s_mdbo,
                s_ack_cyc, s_ack_cnt, s_dbi, s_mreq_last);
      n_checks++;
      if (s_saw || s_ack_cyc != 2 || s_ack_cnt != 1)
         $display("FAIL regwrite: saw=%0d ack_cyc=%0d acks=%0d want 0 2 1", s_saw, s_ack_cyc, s_ack_cnt);
      else n_pass++;
      do_access(1'b0, 16'h6123, 8'h00, 1, 8'h5A, 0, s_saw, s_madr, s_mwrt, s_mdbo,
                s_ack_cyc, s_ack_cnt, s_dbi, s_mreq_last);
      n_checks++;
      if (!s_saw || s_madr !== {5'd21, 7'h05, 13'h0123} || s_mwrt !== 1'b0)
         $display("FAIL mapped_read_adr: adr=%h wrt=%b want %h 0", s_madr, s_mwrt, {5'd21, 7'h05, 13'h0123});
      else n_pass++;
      n_checks++;
      if (s_dbi !== 8'h5A || s_ack_cyc != 3 || s_ack_cnt != 1)
         $display("FAIL mapped_read_data: dbi=%h ack_cyc=%0d acks=%0d want 5a 3 1", s_dbi, s_ack_cyc, s_ack_cnt);
      else n_pass++;
      n_checks++;
      if (dbi !== 8'h5A)
         $display("FAIL dbi_hold: dbi=%h want 5a", dbi);
      else n_pass++;
   endtask

   task automatic test_write_protect();
      do_access(1'b1, 16'h7000, 8'h03, 1, 8'h00, 0, s_saw, s_madr, s_mwrt, s_mdbo,
                s_ack_cyc, s_ack_cnt, s_dbi, s_mreq_last);
      do_access(1'b1, 16'h8010, 8'h77, 1, 8'h00, 0, s_saw, s_madr, s_mwrt, s_mdbo,
                s_ack_cyc, s_ack_cnt, s_dbi, s_mreq_last);
      n_checks++;
      if (s_saw || s_ack_cyc != 2 || s_ack_cnt != 1)
         $display("FAIL protected_write: saw=%0d ack_cyc=%0d acks=%0d want 0 2 1", s_saw, s_ack_cyc, s_ack_cnt);
      else n_pass++;
      do_access(1'b1, 16'h7000, 8'h83, 1, 8'h00, 0, s_saw, s_madr, s_mwrt, s_mdbo,
                s_ack_cyc, s_ack_cnt, s_dbi, s_mreq_last);
      do_access(1'b1, 16'h8010, 8'h77, 1, 8'h00, 0, s_saw, s_madr, s_mwrt, s_mdbo,
                s_ack_cyc, s_ack_cnt, s_dbi, s_mreq_last);
      n_checks++;
      if (!s_saw || s_mwrt !== 1'b1 || s_mdbo !== 8'h77 || s_madr !== {5'd21, 7'h03, 13'h0010})
         $display("FAIL enabled_write: saw=%0d wrt=%b dbo=%h adr=%h want 1 1 77 %h",
                  s_saw, s_mwrt, s_mdbo, s_madr, {5'd21, 7'h03, 13'h0010});
      else n_pass++;
      n_checks++;
      if (s_ack_cyc != 3 || s_ack_cnt != 1 || dbi !== 8'h5A)
         $display("FAIL enabled_write_ack: ack_cyc=%0d acks=%0d dbi=%h want 3 1 5a", s_ack_cyc, s_ack_cnt, dbi);
      else n_pass++;
   endtask

   task automatic test_out_of_range();
      logic [15:0] addrs [2] = '{16'h0100, 16'hC000};
      for (int i = 0; i < 2; i++) begin
         do_access(1'b0, addrs[i], 8'h00, 1, 8'h42, 4, s_saw, s_madr, s_mwrt, s_mdbo,
                   s_ack_cyc, s_ack_cnt, s_dbi, s_mreq_last);
         n_checks++;
         if (s_saw || s_dbi !== 8'hFF || s_ack_cnt != 1 || s_ack_cyc != 2)
            $display("FAIL out_of_range_%h: saw=%0d dbi=%h acks=%0d ack_cyc=%0d want 0 ff 1 2",
                     addrs[i], s_saw, s_dbi, s_ack_cnt, s_ack_cyc);
         else n_pass++;
      end
   endtask

   task automatic test_timeout();
      do_access(1'b0, 16'h4004, 8'h00, 0, 8'h00, 0, s_saw, s_madr, s_mwrt, s_mdbo,
                s_ack_cyc, s_ack_cnt, s_dbi, s_mreq_last);
      n_checks++;
      if (!s_saw || s_mreq_last != TIMEOUT + 1)
         $display("FAIL timeout_mreq: saw=%0d last_high_cycle=%0d want 1 %0d", s_saw, s_mreq_last, TIMEOUT + 1);
      else n_pass++;
      n_checks++;
      if (s_ack_cyc != TIMEOUT + 3 || s_ack_cnt != 1 || s_dbi !== 8'hFF)
         $display("FAIL timeout_ack: ack_cyc=%0d acks=%0d dbi=%h want %0d 1 ff", s_ack_cyc, s_ack_cnt, s_dbi, TIMEOUT + 3);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int acks = 0;
      @(negedge clk21m);
      req = 1'b1; wrt = 1'b0; adr = 16'h6000;
      @(negedge clk21m);
      n_checks++;
      if (mem_req !== 1'b1)
         $display("FAIL mid_launch: mem_req=%b want 1", mem_req);
      else n_pass++;
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (mem_req !== 1'b0)
         $display("FAIL mid_reset_async: mem_req=%b want 0", mem_req);
      else n_pass++;
      @(negedge clk21m);
      req = 1'b0;
      @(negedge clk21m);
      reset = 1'b0;
      @(negedge clk21m);
      mem_ack = 1'b1; mem_dbi = 8'h33;
      @(negedge clk21m);
      mem_ack = 1'b0;
      for (int n = 0; n < 5; n++) begin
         if (ack) acks++;
         @(negedge clk21m);
      end
      n_checks++;
      if (acks != 0 || mem_req !== 1'b0 || dbi !== 8'hFF)
         $display("FAIL stray_mem_ack: acks=%0d mem_req=%b dbi=%h want 0 0 ff", acks, mem_req, dbi);
      else n_pass++;
      do_access(1'b0, 16'h6000, 8'h00, 1, 8'h01, 0, s_saw, s_madr, s_mwrt, s_mdbo,
                s_ack_cyc, s_ack_cnt, s_dbi, s_mreq_last);
      n_checks++;
      if (!s_saw || s_madr[19:13] !== 7'h01)
         $display("FAIL bank1_after_reset: saw=%0d bank=%h want 01", s_saw, s_madr[19:13]);
      else n_pass++;
      do_access(1'b0, 16'h8000, 8'h00, 1, 8'h02, 0, s_saw, s_madr, s_mwrt, s_mdbo,
                s_ack_cyc, s_ack_cnt, s_dbi, s_mreq_last);
      n_checks++;
      if (!s_saw || s_madr[19:13] !== 7'h02)
         $display("FAIL bank2_after_reset: saw=%0d bank=%h want 02", s_saw, s_madr[19:13]);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_bank_defaults();
      test_bank_write_read();
      test_write_protect();
      test_out_of_range();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
